// File: rtl/multi_port_bram_arbiter_if.sv
// multi_port_bram_arbiter_if: requester-side and memory-side bus of the BRAM port arbiter
//   req_*   per-port request slices (port i at slice i), req_ready one-hot grant
//   resp_*  one-hot response strobe plus shared response data/address
//   mem_*   single issued access toward the memory and its fixed-latency read data
//   protocol_err sticky flag raised when an expected memory response is missing
//   slave modport is the arbiter; master modport is the surrounding environment
interface multi_port_bram_arbiter_if #(
  parameter int NUM_PORTS    = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32
);
  logic [NUM_PORTS-1:0]                req_read;
  logic [NUM_PORTS-1:0]                req_write;
  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   req_byte_en;
  logic [NUM_PORTS*ADDRESS_BITS-1:0]   req_address;
  logic [NUM_PORTS*DATA_WIDTH-1:0]     req_data;
  logic [NUM_PORTS-1:0]                req_ready;
  logic [NUM_PORTS-1:0]                resp_valid;
  logic [DATA_WIDTH-1:0]               resp_data;
  logic [ADDRESS_BITS-1:0]             resp_address;
  logic                                mem_ready;
  logic                                mem_read;
  logic                                mem_write;
  logic [DATA_WIDTH/8-1:0]             mem_byte_en;
  logic [ADDRESS_BITS-1:0]             mem_address;
  logic [DATA_WIDTH-1:0]               mem_data_out;
  logic [DATA_WIDTH-1:0]               mem_data_in;
  logic                                mem_valid;
  logic                                protocol_err;
  modport slave (
    input  req_read, req_write, req_byte_en, req_address, req_data,
    input  mem_ready, mem_data_in, mem_valid,
    output req_ready, resp_valid, resp_data, resp_address,
    output mem_read, mem_write, mem_byte_en, mem_address, mem_data_out,
    output protocol_err
  );
  modport master (
    output req_read, req_write, req_byte_en, req_address, req_data,
    output mem_ready, mem_data_in, mem_valid,
    input  req_ready, resp_valid, resp_data, resp_address,
    input  mem_read, mem_write, mem_byte_en, mem_address, mem_data_out,
    input  protocol_err
  );
endinterface

// File: rtl/multi_port_bram_arbiter.sv
// multi_port_bram_arbiter: round-robin sharing of one BRAM port among NUM_PORTS requesters
//   clk_i   system clock
//   rst_ni  synchronous active-low reset; all outputs forced to 0 while low
//   bus     arbiter side of multi_port_bram_arbiter_if (requests, responses, memory port)
module multi_port_bram_arbiter #(
  parameter int NUM_PORTS    = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int READ_LATENCY = 1
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  multi_port_bram_arbiter_if.slave bus
);
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BW = DATA_WIDTH / 8;
  localparam int L  = READ_LATENCY;
  logic [NUM_PORTS-1:0]           active;
  logic                           gnt_found;
  logic                           gnt;
  logic [IW-1:0]                  cand;
  logic [IW-1:0]                  gnt_idx;
  logic [IW-1:0]                  last_grant_q;
  logic [IW-1:0]                  last_grant_d;
  logic [L-1:0]                   tag_v_q;
  logic [L-1:0]                   tag_w_q;
  logic [L-1:0][IW-1:0]           tag_p_q;
  logic [L-1:0][ADDRESS_BITS-1:0] tag_a_q;
  logic                           err_q;
  logic                           err_d;
  logic                           resp_v;
  assign active = bus.req_read | bus.req_write;
  // Scan from the farthest candidate back to last_grant+1 so the nearest active port wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = IW'((int'(last_grant_q) + k) % NUM_PORTS);
      if (active[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end
  assign gnt          = rst_ni & bus.mem_ready & gnt_found;
  assign last_grant_d = gnt ? gnt_idx : last_grant_q;
  assign resp_v       = rst_ni & tag_v_q[L-1];
  assign err_d        = err_q | (resp_v & ~bus.mem_valid);
  // Tag pipeline advances every cycle; its tail lines up with mem_data_in for that access.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tag_v_q      <= '0;
      tag_w_q      <= '0;
      tag_p_q      <= '0;
      tag_a_q      <= '0;
      last_grant_q <= IW'(NUM_PORTS - 1);
      err_q        <= 1'b0;
    end else begin
      tag_v_q[0]   <= gnt;
      tag_w_q[0]   <= bus.req_write[gnt_idx];
      tag_p_q[0]   <= gnt_idx;
      tag_a_q[0]   <= bus.req_address[gnt_idx*ADDRESS_BITS +: ADDRESS_BITS];
      for (int i = 1; i < L; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_w_q[i] <= tag_w_q[i-1];
        tag_p_q[i] <= tag_p_q[i-1];
        tag_a_q[i] <= tag_a_q[i-1];
      end
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end
  assign bus.req_ready    = gnt ? (NUM_PORTS'(1) << gnt_idx) : '0;
  assign bus.mem_write    = gnt & bus.req_write[gnt_idx];
  assign bus.mem_read     = gnt & bus.req_read[gnt_idx] & ~bus.req_write[gnt_idx];
  assign bus.mem_byte_en  = gnt ? bus.req_byte_en[gnt_idx*BW +: BW] : '0;
  assign bus.mem_address  = gnt ? bus.req_address[gnt_idx*ADDRESS_BITS +: ADDRESS_BITS] : '0;
  assign bus.mem_data_out = gnt ? bus.req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.resp_valid   = resp_v ? (NUM_PORTS'(1) << tag_p_q[L-1]) : '0;
  assign bus.resp_address = resp_v ? tag_a_q[L-1] : '0;
  // Write acknowledgements carry no data.
  assign bus.resp_data    = (resp_v & ~tag_w_q[L-1]) ? bus.mem_data_in : '0;
  assign bus.protocol_err = rst_ni & err_q;
endmodule

// File: tb/tb_multi_port_bram_arbiter.sv
// tb_multi_port_bram_arbiter: table, directed and random checks of the BRAM port arbiter
module tb_multi_port_bram_arbiter;
  localparam int NP = 3;
  localparam int DW = 32;
  localparam int AB = 32;
  localparam int BW = DW / 8;
  localparam int L  = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last = NP - 1;
  int mg = -1;
  bit err = 1'b0;
  bit mr = 1'b0;
  typedef struct {
    int            due;
    int            port;
    logic [AB-1:0] addr;
    bit            wr;
  } tag_t;
  tag_t q[$];
  typedef struct {
    logic [NP-1:0] rd;
    logic [NP-1:0] wr;
    logic          mrdy;
    int            gp;
    int            rp;
    logic          mrd;
    logic          mwr;
  } vec_t;
  vec_t tbl[16];
  multi_port_bram_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDRESS_BITS(AB)) bus();
  multi_port_bram_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .READ_LATENCY(L)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, a, e);
    end
  endtask
  task automatic set_port(input int p, input logic rd, input logic wr, input logic [AB-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] be);
    bus.req_read[p] = rd;
    bus.req_write[p] = wr;
    bus.req_address[p*AB +: AB] = a;
    bus.req_data[p*DW +: DW] = d;
    bus.req_byte_en[p*BW +: BW] = be;
  endtask
  task automatic idle();
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, 1'b0, '0, '0, '0);
  endtask
  // Reference: round-robin choice from the last granted port, queue of responses due L cycles later.
  task automatic model_check();
    logic [NP-1:0] er, ev;
    logic [AB-1:0] ea, era;
    logic [DW-1:0] ed, erd;
    logic [BW-1:0] eb;
    logic ew, erd_en;
    mg = -1;
    if (rst_n && bus.mem_ready)
      for (int k = 1; k <= NP; k++)
        if (mg < 0 && (bus.req_read[(last + k) % NP] || bus.req_write[(last + k) % NP]))
          mg = (last + k) % NP;
    er = '0; ea = '0; ed = '0; eb = '0; ew = 1'b0; erd_en = 1'b0;
    if (mg >= 0) begin
      er[mg] = 1'b1;
      ew = bus.req_write[mg];
      erd_en = bus.req_read[mg] & ~ew;
      ea = bus.req_address[mg*AB +: AB];
      ed = bus.req_data[mg*DW +: DW];
      eb = bus.req_byte_en[mg*BW +: BW];
    end
    mr = rst_n && q.size() > 0 && q[0].due == cyc;
    ev = '0; era = '0; erd = '0;
    if (mr) begin
      ev[q[0].port] = 1'b1;
      era = q[0].addr;
      erd = q[0].wr ? '0 : bus.mem_data_in;
    end
    check("m_req_ready", bus.req_ready, er);
    check("m_mem_read", bus.mem_read, erd_en);
    check("m_mem_write", bus.mem_write, ew);
    check("m_mem_address", bus.mem_address, ea);
    check("m_mem_data_out", bus.mem_data_out, ed);
    check("m_mem_byte_en", bus.mem_byte_en, eb);
    check("m_resp_valid", bus.resp_valid, ev);
    check("m_resp_address", bus.resp_address, era);
    check("m_resp_data", bus.resp_data, erd);
    check("m_protocol_err", bus.protocol_err, err && rst_n);
  endtask
  task automatic model_advance();
    tag_t t;
    if (!rst_n) begin
      q.delete();
      last = NP - 1;
      err = 1'b0;
    end else begin
      if (mr) begin
        if (!bus.mem_valid) err = 1'b1;
        void'(q.pop_front());
      end
      if (mg >= 0) begin
        t.due = cyc + L;
        t.port = mg;
        t.addr = bus.req_address[mg*AB +: AB];
        t.wr = bus.req_write[mg];
        q.push_back(t);
        last = mg;
      end
    end
    cyc++;
  endtask
  task automatic tick();
    model_check();
    model_advance();
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", bus.req_ready, '0);
    check("rst_mem_read", bus.mem_read, 1'b0);
    check("rst_mem_write", bus.mem_write, 1'b0);
    check("rst_resp_valid", bus.resp_valid, '0);
    tick();
    #1;
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    tbl[0]  = '{3'b011, 3'b000, 1'b1,  0, -1, 1'b1, 1'b0};
    tbl[1]  = '{3'b011, 3'b000, 1'b1,  1, -1, 1'b1, 1'b0};
    tbl[2]  = '{3'b011, 3'b000, 1'b1,  0, -1, 1'b1, 1'b0};
    tbl[3]  = '{3'b011, 3'b000, 1'b1,  1,  0, 1'b1, 1'b0};
    tbl[4]  = '{3'b011, 3'b000, 1'b0, -1,  1, 1'b0, 1'b0};
    tbl[5]  = '{3'b011, 3'b000, 1'b0, -1,  0, 1'b0, 1'b0};
    tbl[6]  = '{3'b011, 3'b000, 1'b0, -1,  1, 1'b0, 1'b0};
    tbl[7]  = '{3'b011, 3'b000, 1'b1,  0, -1, 1'b1, 1'b0};
    tbl[8]  = '{3'b010, 3'b000, 1'b1,  1, -1, 1'b1, 1'b0};
    tbl[9]  = '{3'b010, 3'b000, 1'b1,  1, -1, 1'b1, 1'b0};
    tbl[10] = '{3'b100, 3'b000, 1'b1,  2,  0, 1'b1, 1'b0};
    tbl[11] = '{3'b000, 3'b001, 1'b1,  0,  1, 1'b0, 1'b1};
    tbl[12] = '{3'b000, 3'b000, 1'b1, -1,  1, 1'b0, 1'b0};
    tbl[13] = '{3'b000, 3'b000, 1'b1, -1,  2, 1'b0, 1'b0};
    tbl[14] = '{3'b000, 3'b000, 1'b1, -1,  0, 1'b0, 1'b0};
    tbl[15] = '{3'b000, 3'b000, 1'b1, -1, -1, 1'b0, 1'b0};
    idle();
    bus.mem_ready = 1'b1;
    bus.mem_valid = 1'b1;
    bus.mem_data_in = '0;
    @(negedge clk);
    do_reset();
    #1;
    check("post_rst_ready", bus.req_ready, '0);
    check("post_rst_resp_valid", bus.resp_valid, '0);
    check("post_rst_protocol_err", bus.protocol_err, 1'b0);
    tick();
    // Alternating grants, stall with mem_ready low, resume order, single-port and write traffic.
    for (int i = 0; i < 16; i++) begin
      for (int p = 0; p < NP; p++)
        set_port(p, tbl[i].rd[p], tbl[i].wr[p], 32'h100 + 32'(p * 4), 32'hA000_0000 + 32'(p), 4'hF);
      bus.mem_ready = tbl[i].mrdy;
      bus.mem_valid = 1'b1;
      bus.mem_data_in = $urandom;
      #1;
      check($sformatf("tbl%0d_ready", i), bus.req_ready, tbl[i].gp < 0 ? 3'b000 : 3'(1 << tbl[i].gp));
      check($sformatf("tbl%0d_resp_valid", i), bus.resp_valid, tbl[i].rp < 0 ? 3'b000 : 3'(1 << tbl[i].rp));
      check($sformatf("tbl%0d_mem_read", i), bus.mem_read, tbl[i].mrd);
      check($sformatf("tbl%0d_mem_write", i), bus.mem_write, tbl[i].mwr);
      if (tbl[i].gp >= 0)
        check($sformatf("tbl%0d_mem_address", i), bus.mem_address, 32'h100 + 32'(tbl[i].gp * 4));
      tick();
    end
    // Port 1 alone: four back-to-back grants, responses L cycles after each.
    idle();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_port(1, i < 4, 1'b0, 32'h200 + 32'(i), '0, 4'hF);
      #1;
      check($sformatf("p1_burst%0d_ready", i), bus.req_ready, i < 4 ? 3'b010 : 3'b000);
      check($sformatf("p1_burst%0d_resp_valid", i), bus.resp_valid, (i >= L && i < L + 4) ? 3'b010 : 3'b000);
      if (i >= L && i < L + 4)
        check($sformatf("p1_burst%0d_resp_address", i), bus.resp_address, 32'h200 + 32'(i - L));
      tick();
    end
    // Read and write together: the write wins, the ack carries zero data.
    idle();
    do_reset();
    set_port(0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0011);
    #1;
    check("rw_ready", bus.req_ready, 3'b001);
    check("rw_mem_write", bus.mem_write, 1'b1);
    check("rw_mem_read", bus.mem_read, 1'b0);
    check("rw_mem_address", bus.mem_address, 32'h10);
    check("rw_mem_data_out", bus.mem_data_out, 32'hDEAD_BEEF);
    check("rw_mem_byte_en", bus.mem_byte_en, 4'b0011);
    tick();
    idle();
    for (int i = 1; i < L; i++) begin
      #1;
      tick();
    end
    bus.mem_data_in = 32'h1234_5678;
    #1;
    check("rw_ack_valid", bus.resp_valid, 3'b001);
    check("rw_ack_data", bus.resp_data, '0);
    check("rw_ack_address", bus.resp_address, 32'h10);
    tick();
    // Reset one cycle after a grant discards the in-flight response.
    do_reset();
    set_port(0, 1'b1, 1'b0, 32'h20, '0, 4'hF);
    #1;
    check("inflight_grant", bus.req_ready, 3'b001);
    tick();
    rst_n = 1'b0;
    set_port(1, 1'b1, 1'b0, 32'h24, '0, 4'hF);
    #1;
    check("inflight_rst_ready", bus.req_ready, 3'b000);
    check("inflight_rst_mem_read", bus.mem_read, 1'b0);
    tick();
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < L + 1; i++) begin
      #1;
      check($sformatf("inflight_drop%0d", i), bus.resp_valid, 3'b000);
      tick();
    end
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b0, 32'h30, '0, 4'hF);
    #1;
    check("inflight_port0_first", bus.req_ready, 3'b001);
    tick();
    // Missing memory response: strobe still fires, error is sticky until reset.
    idle();
    do_reset();
    set_port(2, 1'b1, 1'b0, 32'h40, '0, 4'hF);
    #1;
    check("perr_grant", bus.req_ready, 3'b100);
    tick();
    idle();
    for (int i = 1; i < L; i++) begin
      #1;
      tick();
    end
    bus.mem_valid = 1'b0;
    #1;
    check("perr_strobe", bus.resp_valid, 3'b100);
    check("perr_not_yet", bus.protocol_err, 1'b0);
    tick();
    bus.mem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("perr_sticky%0d", i), bus.protocol_err, 1'b1);
      tick();
    end
    do_reset();
    #1;
    check("perr_cleared", bus.protocol_err, 1'b0);
    tick();
    // Random traffic against the reference model, with occasional resets and missing responses.
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      for (int p = 0; p < NP; p++)
        set_port(p, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom, $urandom,
                 4'($urandom_range(0, 15)));
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      bus.mem_valid = ($urandom_range(0, 19) != 0);
      bus.mem_data_in = $urandom;
      #1;
      tick();
    end
    rst_n = 1'b1;
    idle();
    #1;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
